in_channel: RTL and testbench
=============================

Name: in_channel

Overview:
- Input channel feeding the processor's `in` and `inSize` instructions; the counterpart of the out channel that `out` writes.
- An external loader pushes words through a valid/ready handshake into a circular buffer of NIn words.
- The instruction executor pops words in arrival order and can query the current occupancy.
- Sits between the test harness/loader and the instruction-execution block, replacing the bare inMem/inMemPos pair.

Parameters:
- MemoryElementWidth, 12, width of each channel word (matches memory element width).
- NIn, 16, buffer depth in words; any value >= 2, not necessarily a power of two.
- CW, $clog2(NIn+1), width of the occupancy count.

Ports:
- clock  input  1  single system clock; all state changes on posedge.
- reset  input  1  synchronous, active-high reset.
- loadValid  input  1  loader presents a word.
- loadData  input  MemoryElementWidth  word from loader.
- loadReady  output  1  buffer can accept a word this cycle.
- inRead  input  1  executor pops one word (the `in` instruction).
- inData  output  MemoryElementWidth  popped word, registered.
- inDataValid  output  1  one-cycle pulse: inData holds the word popped in the previous cycle.
- inSize  output  CW  words currently held (the `inSize` instruction).
- inEmpty  output  1  inSize == 0.
- inFull  output  1  inSize == NIn.
- underflow  output  1  sticky: a pop was attempted while empty.

Behaviour:
- Reset (clock edge with reset=1):
  - Write pointer, read pointer and count go to 0.
  - inData=0, inDataValid=0, underflow=0.
  - Outputs are therefore loadReady=1, inEmpty=1, inFull=0, inSize=0.
  - Buffer contents are not cleared.
  - Reset overrides every simultaneous push or pop; a word offered in the reset cycle is dropped.
- Derived outputs:
  - loadReady = !inFull, combinational from the registered count.
  - inEmpty and inFull are combinational from the registered count.
- Push (loadValid & loadReady at posedge):
  - mem[wp] <= loadData.
  - wp <= (wp == NIn-1) ? 0 : wp+1.
  - The word is visible to a pop no earlier than the next cycle.
- Pop (inRead at posedge):
  - If count > 0: inData <= mem[rp], rp advances with the same wrap rule as wp, inDataValid <= 1. Latency is one cycle, from the inRead edge to the inDataValid edge.
  - If count == 0: inData <= 0, inDataValid <= 1, underflow <= 1. Pointers and count are unchanged. The executor receives 0, which matches the existing behaviour of reading an exhausted input.
- inDataValid is 0 in every cycle not following an inRead.
- Count update:
  - +1 on an accepted push only.
  - -1 on a successful pop only.
  - Unchanged when both occur in the same cycle.
  - Never exceeds NIn, never drops below 0.
- Simultaneous events:
  - Full and push+pop in the same cycle: loadReady is 0, so the push is not accepted. The pop proceeds and count becomes NIn-1.
  - Empty and push+pop in the same cycle: there is no bypass. The pop underflows and returns 0; the push is accepted and count becomes 1.
  - Non-empty, not full, push+pop in the same cycle: both occur and count is unchanged.
- Wrap-around: pointers wrap at NIn exactly; arrival order is preserved across any number of wraps.
- Loader hold rule: loadData must be held while loadValid=1 and loadReady=0. The block does not capture it early.
- underflow is cleared only by reset.
- Reset asserted mid-stream discards all buffered words. The first pop after reset with no intervening push underflows.

Test Plan:
- Reset then idle: inSize=0, inEmpty=1, loadReady=1, inDataValid=0, underflow=0.
- Push 10,20,30 on consecutive cycles, then pop 3 times: inData=10,20,30, each with inDataValid one cycle after its inRead; inSize ends at 0 and underflow stays 0.
- NIn=16: push 16 words (1..16). Then inFull=1 and loadReady=0; a 17th word held with loadValid=1 is not accepted until one pop occurs. That pop returns 1 and word 17 enters on the following cycle. Draining returns 2..17 in order.
- Wrap: 40 interleaved pushes and pops, never exceeding 5 buffered words, with values 100+k. Pops return 100..139 in order and inSize tracks the reference count every cycle.
- Pop on empty: inData=0, inDataValid=1, underflow=1. A same-cycle push of 7 leaves inSize=1, and the next pop returns 7 with underflow still 1.
- Reset mid-stream with 4 words buffered: inSize=0 and underflow=0 after reset, and the next pop returns 0 and sets underflow.

Source files
------------

// File: rtl/in_channel_if.sv
// Loader and executor handshake bundle for the input channel.
// master = loader/executor side, slave = the channel itself.
interface in_channel_if #(
    parameter int MemoryElementWidth = 12,
    parameter int NIn = 16,
    parameter int CW = $clog2(NIn + 1)
);
    logic                          loadValid;
    logic [MemoryElementWidth-1:0] loadData;
    logic                          loadReady;
    logic                          inRead;
    logic [MemoryElementWidth-1:0] inData;
    logic                          inDataValid;
    logic [CW-1:0]                 inSize;
    logic                          inEmpty;
    logic                          inFull;
    logic                          underflow;

    modport master (
        output loadValid, loadData, inRead,
        input  loadReady, inData, inDataValid, inSize, inEmpty, inFull, underflow
    );

    modport slave (
        input  loadValid, loadData, inRead,
        output loadReady, inData, inDataValid, inSize, inEmpty, inFull, underflow
    );
endinterface

// File: rtl/in_channel.sv
// Input channel: circular word buffer filled by the loader and drained by the
// `in` instruction, with occupancy reporting for `inSize`.
module in_channel #(
    parameter int MemoryElementWidth = 12,
    parameter int NIn = 16,
    parameter int CW = $clog2(NIn + 1)
) (
    input logic         clock,
    input logic         reset,
    in_channel_if.slave ch
);
    localparam int PW = $clog2(NIn);

    logic [MemoryElementWidth-1:0] mem [NIn];
    logic [PW-1:0]                 wp;
    logic [PW-1:0]                 rp;
    logic [CW-1:0]                 count;
    logic                          pushOk;
    logic                          popOk;

    assign ch.inSize    = count;
    assign ch.inEmpty   = (count == '0);
    assign ch.inFull    = (count == CW'(NIn));
    assign ch.loadReady = !ch.inFull;

    assign pushOk = ch.loadValid && ch.loadReady;
    assign popOk  = ch.inRead && (count != '0);

    // Storage has no reset so it can map onto plain RAM; reset only gates writes.
    always_ff @(posedge clock) begin
        if (!reset && pushOk) begin
            mem[wp] <= ch.loadData;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wp             <= '0;
            rp             <= '0;
            count          <= '0;
            ch.inData      <= '0;
            ch.inDataValid <= 1'b0;
            ch.underflow   <= 1'b0;
        end else begin
            if (pushOk) begin
                wp <= (wp == PW'(NIn - 1)) ? '0 : wp + PW'(1);
            end

            ch.inDataValid <= ch.inRead;
            if (ch.inRead) begin
                if (popOk) begin
                    ch.inData <= mem[rp];
                    rp        <= (rp == PW'(NIn - 1)) ? '0 : rp + PW'(1);
                end else begin
                    // Exhausted input reads as zero, as the old inMem path did.
                    ch.inData    <= '0;
                    ch.underflow <= 1'b1;
                end
            end

            unique case ({pushOk, popOk})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

// File: tb/tb_in_channel.sv
// Directed bench for in_channel: ordering, full/empty boundaries, wrap,
// underflow and mid-stream reset.
module tb_in_channel;
    localparam int W   = 12;
    localparam int NIn = 16;
    localparam int CW  = $clog2(NIn + 1);

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   failures = 0;

    in_channel_if #(.MemoryElementWidth(W), .NIn(NIn), .CW(CW)) bus ();

    in_channel #(.MemoryElementWidth(W), .NIn(NIn), .CW(CW)) dut (
        .clock (clock),
        .reset (reset),
        .ch    (bus.slave)
    );

    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic checkValue(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    initial begin
        int refCount;
        int pushed;
        int popped;
        int cyc;
        bit doPush;
        bit doPop;

        bus.loadValid = 1'b0;
        bus.loadData  = '0;
        bus.inRead    = 1'b0;

        // reset then idle
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        step();
        checkValue("rst_inSize", 32'(bus.inSize), 0);
        checkValue("rst_inEmpty", 32'(bus.inEmpty), 1);
        checkValue("rst_inFull", 32'(bus.inFull), 0);
        checkValue("rst_loadReady", 32'(bus.loadReady), 1);
        checkValue("rst_inDataValid", 32'(bus.inDataValid), 0);
        checkValue("rst_underflow", 32'(bus.underflow), 0);

        // push 10,20,30 then pop three
        for (int k = 1; k <= 3; k++) begin
            bus.loadValid = 1'b1;
            bus.loadData  = W'(10 * k);
            step();
        end
        bus.loadValid = 1'b0;
        checkValue("three_inSize", 32'(bus.inSize), 3);
        for (int k = 1; k <= 3; k++) begin
            bus.inRead = 1'b1;
            step();
            checkValue("three_inDataValid", 32'(bus.inDataValid), 1);
            checkValue("three_inData", 32'(bus.inData), 32'(10 * k));
        end
        bus.inRead = 1'b0;
        step();
        checkValue("three_validDrop", 32'(bus.inDataValid), 0);
        checkValue("three_inSizeEnd", 32'(bus.inSize), 0);
        checkValue("three_underflow", 32'(bus.underflow), 0);

        // fill to NIn, hold word 17 until a pop frees a slot
        for (int k = 1; k <= NIn; k++) begin
            bus.loadValid = 1'b1;
            bus.loadData  = W'(k);
            step();
        end
        bus.loadData = W'(17);
        checkValue("full_inFull", 32'(bus.inFull), 1);
        checkValue("full_loadReady", 32'(bus.loadReady), 0);
        checkValue("full_inSize", 32'(bus.inSize), 16);
        step();
        checkValue("full_holdNotTaken", 32'(bus.inSize), 16);
        bus.inRead = 1'b1;
        step();
        checkValue("full_popData", 32'(bus.inData), 1);
        checkValue("full_popSize", 32'(bus.inSize), 15);
        checkValue("full_readyBack", 32'(bus.loadReady), 1);
        bus.inRead = 1'b0;
        step();
        checkValue("full_word17In", 32'(bus.inSize), 16);
        bus.loadValid = 1'b0;
        for (int k = 2; k <= 17; k++) begin
            bus.inRead = 1'b1;
            step();
            checkValue("full_drain", 32'(bus.inData), 32'(k));
        end
        bus.inRead = 1'b0;
        step();
        checkValue("full_drainedSize", 32'(bus.inSize), 0);

        // interleaved wrap with a reference count, at most 5 buffered
        refCount = 0;
        pushed = 0;
        popped = 0;
        cyc = 0;
        while (popped < 40 && cyc < 400) begin
            doPush = (pushed < 40) && (refCount < 5) && (cyc % 3 != 2);
            doPop  = (refCount > 0) && ((cyc % 4 == 1) || (pushed == 40));
            bus.loadValid = doPush;
            bus.loadData  = W'(100 + pushed);
            bus.inRead    = doPop;
            step();
            if (doPush) begin
                pushed++;
                refCount++;
            end
            if (doPop) begin
                checkValue("wrap_data", 32'(bus.inData), 32'(100 + popped));
                popped++;
                refCount--;
            end
            checkValue("wrap_inSize", 32'(bus.inSize), 32'(refCount));
            cyc++;
        end
        bus.loadValid = 1'b0;
        bus.inRead    = 1'b0;
        checkValue("wrap_allPopped", 32'(popped), 40);
        checkValue("wrap_underflow", 32'(bus.underflow), 0);

        // pop on empty with a same-cycle push of 7
        bus.inRead    = 1'b1;
        bus.loadValid = 1'b1;
        bus.loadData  = W'(7);
        step();
        checkValue("empty_inData", 32'(bus.inData), 0);
        checkValue("empty_valid", 32'(bus.inDataValid), 1);
        checkValue("empty_underflow", 32'(bus.underflow), 1);
        checkValue("empty_inSize", 32'(bus.inSize), 1);
        bus.loadValid = 1'b0;
        step();
        checkValue("empty_nextData", 32'(bus.inData), 7);
        checkValue("empty_stickyUf", 32'(bus.underflow), 1);
        checkValue("empty_sizeZero", 32'(bus.inSize), 0);
        bus.inRead = 1'b0;
        step();

        // reset mid-stream with 4 buffered; a word offered during reset is dropped
        for (int k = 0; k < 4; k++) begin
            bus.loadValid = 1'b1;
            bus.loadData  = W'(50 + k);
            step();
        end
        checkValue("mid_inSize", 32'(bus.inSize), 4);
        bus.loadData = W'(99);
        reset = 1'b1;
        step();
        reset = 1'b0;
        bus.loadValid = 1'b0;
        checkValue("mid_rstSize", 32'(bus.inSize), 0);
        checkValue("mid_rstUnderflow", 32'(bus.underflow), 0);
        checkValue("mid_rstEmpty", 32'(bus.inEmpty), 1);
        bus.inRead = 1'b1;
        step();
        checkValue("mid_popData", 32'(bus.inData), 0);
        checkValue("mid_popValid", 32'(bus.inDataValid), 1);
        checkValue("mid_popUnderflow", 32'(bus.underflow), 1);
        bus.inRead = 1'b0;
        step();
        checkValue("mid_validDrop", 32'(bus.inDataValid), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
